// File: rtl/lifo_ext.sv
// Protected synchronous stack with replace-top, read-valid strobe, almost flags and error pulses.
// Optional saturating error counters are compiled in with LIFO_EXT_ERR_CNT_EN.
module lifo_ext #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4,
  parameter int AF_LVL = 2**AWIDTH-1,
  parameter int AE_LVL = 1
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              wrreq_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              rdreq_i,
  output logic [DWIDTH-1:0] q_o,
  output logic              q_valid_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              almost_empty_o,
  output logic              almost_full_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              overflow_o,
  output logic              underflow_o
`ifdef LIFO_EXT_ERR_CNT_EN
  ,
  input  logic              cnt_clr_i,
  output logic [15:0]       ovf_cnt_o,
  output logic [15:0]       udf_cnt_o
`endif
);

  localparam int            DEPTH  = 2**AWIDTH;
  localparam logic [AWIDTH:0] FULL_C = DEPTH[AWIDTH:0];
  localparam logic [AWIDTH:0] AF_C   = AF_LVL[AWIDTH:0];
  localparam logic [AWIDTH:0] AE_C   = AE_LVL[AWIDTH:0];

  logic [DWIDTH-1:0] mem [DEPTH];

  logic              pop_ok;
  logic              push_ok;
  logic [AWIDTH-1:0] top_idx;
  logic [AWIDTH-1:0] wr_idx;
  logic [AWIDTH:0]   usedw_nxt;

  // Decode uses the registered empty/full flags; a pop frees the slot a simultaneous push needs.
  assign pop_ok  = rdreq_i && !empty_o;
  assign push_ok = wrreq_i && (!full_o || pop_ok);
  assign top_idx = usedw_o[AWIDTH-1:0] - AWIDTH'(1);
  assign wr_idx  = pop_ok ? top_idx : usedw_o[AWIDTH-1:0];

  always_comb begin
    usedw_nxt = usedw_o;
    case ({push_ok, pop_ok})
      2'b10:   usedw_nxt = usedw_o + (AWIDTH+1)'(1);
      2'b01:   usedw_nxt = usedw_o - (AWIDTH+1)'(1);
      default: usedw_nxt = usedw_o;
    endcase
  end

  // Storage kept free of reset so it maps onto a plain synchronous RAM.
  always_ff @(posedge clk_i) begin
    if (push_ok && !srst_i) begin
      mem[wr_idx] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      usedw_o        <= '0;
      q_o            <= '0;
      q_valid_o      <= 1'b0;
      empty_o        <= 1'b1;
      full_o         <= 1'b0;
      almost_empty_o <= 1'b1;
      almost_full_o  <= 1'b0;
      overflow_o     <= 1'b0;
      underflow_o    <= 1'b0;
    end else begin
      // Old top is read with the same edge that overwrites it, so replace returns the old value.
      if (pop_ok) begin
        q_o <= mem[top_idx];
      end
      q_valid_o      <= pop_ok;
      usedw_o        <= usedw_nxt;
      empty_o        <= (usedw_nxt == '0);
      full_o         <= (usedw_nxt == FULL_C);
      almost_empty_o <= (usedw_nxt <= AE_C);
      almost_full_o  <= (usedw_nxt >= AF_C);
      overflow_o     <= wrreq_i && !push_ok;
      underflow_o    <= rdreq_i && !pop_ok;
    end
  end

`ifdef LIFO_EXT_ERR_CNT_EN
  always_ff @(posedge clk_i) begin
    if (srst_i || cnt_clr_i) begin
      ovf_cnt_o <= '0;
      udf_cnt_o <= '0;
    end else begin
      if (wrreq_i && !push_ok && ovf_cnt_o != 16'hFFFF) begin
        ovf_cnt_o <= ovf_cnt_o + 16'd1;
      end
      if (rdreq_i && !pop_ok && udf_cnt_o != 16'hFFFF) begin
        udf_cnt_o <= udf_cnt_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lifo_ext.sv
// Bench for lifo_ext at DEPTH=4: directed scenarios plus random traffic against a queue model.
module tb_lifo_ext;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          srst;
  logic          wrreq;
  logic [DW-1:0] data;
  logic          rdreq;
  logic [DW-1:0] q;
  logic          q_valid;
  logic          empty;
  logic          full;
  logic          almost_empty;
  logic          almost_full;
  logic [AW:0]   usedw;
  logic          overflow;
  logic          underflow;
`ifdef LIFO_EXT_ERR_CNT_EN
  logic          cnt_clr;
  logic [15:0]   ovf_cnt;
  logic [15:0]   udf_cnt;
  int            m_ovf_cnt;
  int            m_udf_cnt;
`endif

  lifo_ext #(.DWIDTH(DW), .AWIDTH(AW), .AF_LVL(3), .AE_LVL(1)) dut (
    .clk_i(clk),
    .srst_i(srst),
    .wrreq_i(wrreq),
    .data_i(data),
    .rdreq_i(rdreq),
    .q_o(q),
    .q_valid_o(q_valid),
    .empty_o(empty),
    .full_o(full),
    .almost_empty_o(almost_empty),
    .almost_full_o(almost_full),
    .usedw_o(usedw),
    .overflow_o(overflow),
    .underflow_o(underflow)
`ifdef LIFO_EXT_ERR_CNT_EN
    ,
    .cnt_clr_i(cnt_clr),
    .ovf_cnt_o(ovf_cnt),
    .udf_cnt_o(udf_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard: expected pop data, plus a reference stack
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] stk[$];
  logic [DW-1:0] m_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, advance model, compare #1 after the edge.
  task automatic step(input logic rst, input logic wr, input logic [DW-1:0] d, input logic rd);
    logic pop_ok, push_ok, e_ovf, e_udf, e_qv;
    logic [DW-1:0] top;
    @(negedge clk);
    srst = rst; wrreq = wr; data = d; rdreq = rd;
    e_ovf = 1'b0; e_udf = 1'b0; e_qv = 1'b0;
    if (rst) begin
      stk.delete();
      exp_q.delete();
      m_q = '0;
`ifdef LIFO_EXT_ERR_CNT_EN
      m_ovf_cnt = 0; m_udf_cnt = 0;
`endif
    end else begin
      pop_ok  = rd && (stk.size() > 0);
      push_ok = wr && (stk.size() < DEPTH || pop_ok);
      e_ovf   = wr && !push_ok;
      e_udf   = rd && !pop_ok;
      if (pop_ok) begin
        top = stk.pop_back();
        exp_q.push_back(top);
        m_q  = top;
        e_qv = 1'b1;
      end
      if (push_ok) stk.push_back(d);
`ifdef LIFO_EXT_ERR_CNT_EN
      if (cnt_clr) begin
        m_ovf_cnt = 0; m_udf_cnt = 0;
      end else begin
        if (e_ovf && m_ovf_cnt < 65535) m_ovf_cnt++;
        if (e_udf && m_udf_cnt < 65535) m_udf_cnt++;
      end
`endif
    end
    @(posedge clk);
    #1;
    check("usedw", 32'(usedw), 32'(stk.size()));
    check("empty", 32'(empty), 32'(stk.size() == 0));
    check("full", 32'(full), 32'(stk.size() == DEPTH));
    check("almost_empty", 32'(almost_empty), 32'(stk.size() <= 1));
    check("almost_full", 32'(almost_full), 32'(stk.size() >= 3));
    check("overflow", 32'(overflow), 32'(e_ovf));
    check("underflow", 32'(underflow), 32'(e_udf));
    check("q_valid", 32'(q_valid), 32'(e_qv));
    check("q_hold", 32'(q), 32'(m_q));
    if (q_valid) begin
      if (exp_q.size() == 0) check("q_unexpected", 32'(q_valid), 32'd0);
      else check("q_data", 32'(q), 32'(exp_q.pop_front()));
    end
`ifdef LIFO_EXT_ERR_CNT_EN
    if (!rst) begin
      check("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf_cnt));
      check("udf_cnt", 32'(udf_cnt), 32'(m_udf_cnt));
    end
`endif
  endtask

  task automatic push(input logic [DW-1:0] d); step(1'b0, 1'b1, d, 1'b0); endtask
  task automatic pop();                        step(1'b0, 1'b0, 8'h00, 1'b1); endtask
  task automatic idle();                       step(1'b0, 1'b0, 8'h00, 1'b0); endtask

  initial begin
    logic [DW-1:0] seq [4];
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
    srst = 1'b1; wrreq = 1'b0; data = '0; rdreq = 1'b0; m_q = '0;
`ifdef LIFO_EXT_ERR_CNT_EN
    cnt_clr = 1'b0; m_ovf_cnt = 0; m_udf_cnt = 0;
`endif
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    idle();

    // fill and drain in LIFO order
    for (int i = 0; i < 4; i++) push(seq[i]);
    for (int i = 0; i < 4; i++) pop();
    idle();

    // overflow on full stack, then pop returns the original top
    for (int i = 0; i < 4; i++) push(seq[i]);
    push(8'h55);
    pop();
    for (int i = 0; i < 3; i++) pop();

    // underflow on empty stack: q holds
    pop();
    idle();

    // replace top on [0x11,0x22]
    push(8'h11); push(8'h22);
    step(1'b0, 1'b1, 8'h99, 1'b1);
    pop(); pop();

    // push+pop on empty: push accepted, pop rejected
    step(1'b0, 1'b1, 8'h77, 1'b1);
    pop();

    // replace top while full
    for (int i = 0; i < 4; i++) push(seq[i]);
    step(1'b0, 1'b1, 8'hAB, 1'b1);
    for (int i = 0; i < 4; i++) pop();

    // reset together with a push at usedw=3
    push(8'h01); push(8'h02); push(8'h03);
    step(1'b1, 1'b1, 8'h04, 1'b0);
    idle();

`ifdef LIFO_EXT_ERR_CNT_EN
    for (int i = 0; i < 4; i++) push(seq[i]);
    for (int i = 0; i < 3; i++) push(8'hEE);
    cnt_clr = 1'b1;
    step(1'b0, 1'b1, 8'hEE, 1'b0);
    cnt_clr = 1'b0;
    idle();
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
